decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Multi-lane, buffered successor to the single-instruction combinational decoder. It accepts a group of up to DECODE_WIDTH instructions from fetch using a valid/ready handshake. Each lane is decoded into register indices, a sign-extended immediate and a ctrl_payload_t. Decoded groups are held in a SKID_DEPTH-entry group FIFO and presented to rename under a second valid/ready handshake. The block sits between fetch and rename. It adds JAL, AUIPC, the full branch set, illegal-instruction flagging and flush support.

Parameters:
DECODE_WIDTH, 2, number of instruction lanes per group (1..4)
SKID_DEPTH, 2, number of decoded groups buffered (power of 2, >=2)
ENABLE_JAL_AUIPC, 1, when 0, JAL and AUIPC decode as illegal

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush_i  in  1  discard all buffered groups and any same-cycle input group
fetch_valid_i  in  DECODE_WIDTH  per-lane valid; lane 0 is oldest
fetch_inst_i  in  DECODE_WIDTH*32  instructions; lane k occupies bits [32k+31:32k]
fetch_pc_i  in  32  PC of lane 0
fetch_ready_o  out  1  a group is accepted on clk when (|fetch_valid_i) && fetch_ready_o
dec_valid_o  out  DECODE_WIDTH  per-lane valid of the FIFO head group
dec_rs1_o, dec_rs2_o, dec_rd_o  out  5*DECODE_WIDTH each  register indices, 0 when unused
dec_rs1_valid_o, dec_rs2_valid_o  out  DECODE_WIDTH each  source operand is used
dec_payload_o  out  DECODE_WIDTH x ctrl_payload_t  control payload per lane
rename_ready_i  in  1  head group is consumed on clk when (|dec_valid_o) && rename_ready_i

Behaviour:
- Reset: FIFO count = 0, rd/wr pointers = 0. All dec_* outputs = 0. fetch_ready_o = 1 once rst is deasserted.
- Lane validity is contiguous. The first 0 in fetch_valid_i masks all higher lanes.
- Lane k PC is fetch_pc_i + 4*k, computed modulo 2^32.
- fetch_ready_o = (count < SKID_DEPTH). It must not depend combinationally on rename_ready_i.
- Latency: a group accepted at edge N appears on dec_* after edge N, provided the FIFO was empty.
- Outputs are driven from the registered FIFO head. There is no combinational path from fetch to dec.
- Enqueue and dequeue in the same cycle: count is unchanged. When full, fetch_ready_o = 0, so a same-cycle dequeue does not allow an enqueue.
- Pointers wrap modulo SKID_DEPTH. Count saturates at SKID_DEPTH; there is no overflow or underflow.
- flush_i has priority over everything else. At the next edge: count = 0, pointers = 0, dec_valid_o = 0, and the input group is dropped even if the handshake fired.
- Reset asserted mid-operation immediately clears all state, regardless of clk.
- Per-lane decode (opcode → ALUOp, fu_type):
  - LUI → 100, ALU
  - OP-IMM → 010, ALU; imm is zero-extended for ORI, sign-extended otherwise
  - OP → 001, ALU
  - LOAD → 000, LSU; MemRead = 1, MemToReg = 1
  - STORE → 000, LSU; MemWrite = 1; S-type imm
  - BRANCH → 011, BRANCH; is_branch = 1 for funct3 in {000, 001, 100, 101, 110, 111}; funct3 010 and 011 are illegal; B-type imm
  - JALR → 101, BRANCH; is_jump = 1
  - JAL → 101, BRANCH; is_jump = 1; J-type imm; rd only
  - AUIPC → 110, ALU; U-type imm
- ALUSrc = 1 for OP-IMM, LOAD, STORE, JALR, JAL and AUIPC.
- RegWrite = 1 only for opcodes that write rd, and is forced to 0 when rd = x0. dec_rd_o still carries the instruction's rd field.
- Illegal or unknown opcode: payload.illegal = 1, ALUOp = 111, RegWrite = MemRead = MemWrite = 0, rs/rd = 0, imm = 0. The lane stays valid so that rename can raise an exception.
- payload.pc, payload.inst and payload.imm always reflect the lane's own instruction.

Decomposition:
- pipeline_types package holds:
  - ctrl_payload_t, extended with an illegal bit
  - fu_type_t
  - opcode and funct3 localparams, including JAL = 1101111 and AUIPC = 0010111
  - ALUOp encodings
- Sub-module decode_lane: a purely combinational single-instruction decoder, instantiated DECODE_WIDTH times.
- decode_stage owns lane masking, PC generation, the group FIFO and flush.

Test Plan:
- Reset, then lane 0 = 0xFFF10093 (addi x1,x2,-1) and lane 1 = 0x80006193 (ori x3,x0,0x800), PC 0x1000. Required one cycle later: rs1 = 2, rd = 1, imm = 0xFFFFFFFF, ALUOp = 010. Lane 1 imm = 0x00000800, pc = 0x1004.
- fetch_valid_i = 2'b10. Required: the group is either not accepted, or dec_valid_o = 00 after acceptance; lane 1 is never presented.
- rename_ready_i = 0 with three groups pushed back-to-back. Required: fetch_ready_o = 0 after the 2nd is accepted and the 3rd is held. Then raise rename_ready_i for 3 cycles: groups emerge in order, one per cycle.
- Lane 0 = 0x008000EF (jal x1,+8) and lane 1 = 0x00000000. Required: lane 0 is_jump = 1, imm = 8, RegWrite = 1. Lane 1 illegal = 1, ALUOp = 111. With ENABLE_JAL_AUIPC = 0, lane 0 is illegal.
- FIFO full, then flush_i asserted together with a valid input group. Required next cycle: dec_valid_o = 0, fetch_ready_o = 1, dropped group never appears.
- Assert rst asynchronously between edges with the FIFO holding data. Required: dec_valid_o drops to 0 immediately (no clk edge needed). addi x0,x0,0 afterwards gives RegWrite = 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode types: control payload, functional-unit tags, opcode/funct3
// encodings and ALUOp codes used by the decode stage and its lane decoder.
package pipeline_types;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_LSU    = 2'd1,
    FU_BRANCH = 2'd2
  } fu_type_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_ORI  = 3'b110;

  localparam logic [2:0] ALU_MEM   = 3'b000;
  localparam logic [2:0] ALU_OP    = 3'b001;
  localparam logic [2:0] ALU_OPIMM = 3'b010;
  localparam logic [2:0] ALU_BR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_JUMP  = 3'b101;
  localparam logic [2:0] ALU_AUIPC = 3'b110;
  localparam logic [2:0] ALU_ILL   = 3'b111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    fu_type_t    fu_type;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } ctrl_payload_t;

  typedef struct packed {
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic          rs1_valid;
    logic          rs2_valid;
    ctrl_payload_t payload;
  } dec_lane_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_lane.sv
// Combinational single-instruction decoder: register indices, immediate and
// control payload for one lane. Illegal encodings produce a zeroed, flagged lane.
module decode_lane
  import pipeline_types::*;
#(
  parameter bit ENABLE_JAL_AUIPC = 1'b1
) (
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output dec_lane_t   lane_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        ill;
  logic        wr_rd;

  always_comb begin
    opcode = inst_i[6:0];
    funct3 = inst_i[14:12];
    rd_f   = inst_i[11:7];
    rs1_f  = inst_i[19:15];
    rs2_f  = inst_i[24:20];
    imm_i  = sext12(inst_i[31:20]);
    imm_s  = sext12({inst_i[31:25], inst_i[11:7]});
    imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    imm_u  = {inst_i[31:12], 12'b0};
    imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  end

  always_comb begin
    lane_o              = '0;
    lane_o.payload.pc   = pc_i;
    lane_o.payload.inst = inst_i;
    lane_o.payload.fu_type = FU_ALU;
    ill   = 1'b0;
    wr_rd = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        lane_o.payload.alu_op = ALU_LUI;
        lane_o.payload.imm    = imm_u;
        lane_o.rd             = rd_f;
        wr_rd                 = 1'b1;
      end
      OPC_OP_IMM: begin
        lane_o.payload.alu_op  = ALU_OPIMM;
        lane_o.payload.alu_src = 1'b1;
        lane_o.payload.imm     = (funct3 == F3_ORI) ? {20'b0, inst_i[31:20]} : imm_i;
        lane_o.rd              = rd_f;
        lane_o.rs1             = rs1_f;
        lane_o.rs1_valid       = 1'b1;
        wr_rd                  = 1'b1;
      end
      OPC_OP: begin
        lane_o.payload.alu_op = ALU_OP;
        lane_o.rd             = rd_f;
        lane_o.rs1            = rs1_f;
        lane_o.rs2            = rs2_f;
        lane_o.rs1_valid      = 1'b1;
        lane_o.rs2_valid      = 1'b1;
        wr_rd                 = 1'b1;
      end
      OPC_LOAD: begin
        lane_o.payload.alu_op     = ALU_MEM;
        lane_o.payload.fu_type    = FU_LSU;
        lane_o.payload.alu_src    = 1'b1;
        lane_o.payload.mem_read   = 1'b1;
        lane_o.payload.mem_to_reg = 1'b1;
        lane_o.payload.imm        = imm_i;
        lane_o.rd                 = rd_f;
        lane_o.rs1                = rs1_f;
        lane_o.rs1_valid          = 1'b1;
        wr_rd                     = 1'b1;
      end
      OPC_STORE: begin
        lane_o.payload.alu_op    = ALU_MEM;
        lane_o.payload.fu_type   = FU_LSU;
        lane_o.payload.alu_src   = 1'b1;
        lane_o.payload.mem_write = 1'b1;
        lane_o.payload.imm       = imm_s;
        lane_o.rs1               = rs1_f;
        lane_o.rs2               = rs2_f;
        lane_o.rs1_valid         = 1'b1;
        lane_o.rs2_valid         = 1'b1;
      end
      OPC_BRANCH: begin
        lane_o.payload.alu_op    = ALU_BR;
        lane_o.payload.fu_type   = FU_BRANCH;
        lane_o.payload.is_branch = 1'b1;
        lane_o.payload.imm       = imm_b;
        lane_o.rs1               = rs1_f;
        lane_o.rs2               = rs2_f;
        lane_o.rs1_valid         = 1'b1;
        lane_o.rs2_valid         = 1'b1;
        ill = !(funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
      end
      OPC_JALR: begin
        lane_o.payload.alu_op  = ALU_JUMP;
        lane_o.payload.fu_type = FU_BRANCH;
        lane_o.payload.is_jump = 1'b1;
        lane_o.payload.alu_src = 1'b1;
        lane_o.payload.imm     = imm_i;
        lane_o.rd              = rd_f;
        lane_o.rs1             = rs1_f;
        lane_o.rs1_valid       = 1'b1;
        wr_rd                  = 1'b1;
      end
      OPC_JAL: begin
        lane_o.payload.alu_op  = ALU_JUMP;
        lane_o.payload.fu_type = FU_BRANCH;
        lane_o.payload.is_jump = 1'b1;
        lane_o.payload.alu_src = 1'b1;
        lane_o.payload.imm     = imm_j;
        lane_o.rd              = rd_f;
        wr_rd                  = 1'b1;
        ill                    = !ENABLE_JAL_AUIPC;
      end
      OPC_AUIPC: begin
        lane_o.payload.alu_op  = ALU_AUIPC;
        lane_o.payload.alu_src = 1'b1;
        lane_o.payload.imm     = imm_u;
        lane_o.rd              = rd_f;
        wr_rd                  = 1'b1;
        ill                    = !ENABLE_JAL_AUIPC;
      end
      default: ill = 1'b1;
    endcase

    // Illegal lanes keep only pc/inst so rename can still raise the exception.
    if (ill) begin
      lane_o                 = '0;
      lane_o.payload.pc      = pc_i;
      lane_o.payload.inst    = inst_i;
      lane_o.payload.fu_type = FU_ALU;
      lane_o.payload.alu_op  = ALU_ILL;
      lane_o.payload.illegal = 1'b1;
    end else begin
      lane_o.payload.reg_write = wr_rd && (rd_f != 5'd0);
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Multi-lane decode stage: masks fetch lanes, decodes each lane and buffers
// decoded groups in a small FIFO presented to rename with valid/ready.
module decode_stage
  import pipeline_types::*;
#(
  parameter int DECODE_WIDTH     = 2,
  parameter int SKID_DEPTH       = 2,
  parameter bit ENABLE_JAL_AUIPC = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [DECODE_WIDTH-1:0]        fetch_valid_i,
  input  logic [DECODE_WIDTH*32-1:0]     fetch_inst_i,
  input  logic [31:0]                    fetch_pc_i,
  output logic                           fetch_ready_o,
  output logic [DECODE_WIDTH-1:0]        dec_valid_o,
  output logic [DECODE_WIDTH*5-1:0]      dec_rs1_o,
  output logic [DECODE_WIDTH*5-1:0]      dec_rs2_o,
  output logic [DECODE_WIDTH*5-1:0]      dec_rd_o,
  output logic [DECODE_WIDTH-1:0]        dec_rs1_valid_o,
  output logic [DECODE_WIDTH-1:0]        dec_rs2_valid_o,
  output ctrl_payload_t [DECODE_WIDTH-1:0] dec_payload_o,
  input  logic                           rename_ready_i
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DECODE_WIDTH-1:0] lane_vld;
  logic                    run;
  dec_lane_t               lane_dec [DECODE_WIDTH];

  dec_lane_t               mem_lane_q [SKID_DEPTH][DECODE_WIDTH];
  logic [DECODE_WIDTH-1:0] mem_vld_q  [SKID_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic [DECODE_WIDTH-1:0] head_vld;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A lane is valid only if it and every older lane are valid.
  always_comb begin
    lane_vld = '0;
    run      = 1'b1;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      run         = run & fetch_valid_i[k];
      lane_vld[k] = run;
    end
  end

  for (genvar k = 0; k < DECODE_WIDTH; k++) begin : g_lane
    decode_lane #(
      .ENABLE_JAL_AUIPC(ENABLE_JAL_AUIPC)
    ) u_lane (
      .inst_i (fetch_inst_i[32*k +: 32]),
      .pc_i   (fetch_pc_i + 32'(4 * k)),
      .lane_o (lane_dec[k])
    );
  end

  // A handshake with lane 0 invalid is accepted but leaves nothing to buffer.
  always_comb begin
    fetch_ready_o = (count_q < CNT_W'(SKID_DEPTH));
    push = (|fetch_valid_i) && fetch_ready_o && lane_vld[0] && !flush_i;
    pop  = (count_q != '0) && rename_ready_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_vld_q[wr_ptr_q] <= lane_vld;
      for (int k = 0; k < DECODE_WIDTH; k++) begin
        mem_lane_q[wr_ptr_q][k] <= lane_dec[k];
      end
    end
  end

  always_comb begin
    head_vld        = (count_q != '0) ? mem_vld_q[rd_ptr_q] : '0;
    dec_valid_o     = head_vld;
    dec_rs1_o       = '0;
    dec_rs2_o       = '0;
    dec_rd_o        = '0;
    dec_rs1_valid_o = '0;
    dec_rs2_valid_o = '0;
    dec_payload_o   = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      if (head_vld[k]) begin
        dec_rs1_o[5*k +: 5] = mem_lane_q[rd_ptr_q][k].rs1;
        dec_rs2_o[5*k +: 5] = mem_lane_q[rd_ptr_q][k].rs2;
        dec_rd_o[5*k +: 5]  = mem_lane_q[rd_ptr_q][k].rd;
        dec_rs1_valid_o[k]  = mem_lane_q[rd_ptr_q][k].rs1_valid;
        dec_rs2_valid_o[k]  = mem_lane_q[rd_ptr_q][k].rs2_valid;
        dec_payload_o[k]    = mem_lane_q[rd_ptr_q][k].payload;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: per-instruction decode table plus
// handshake, back-pressure, flush and asynchronous reset sequences.
module tb_decode_stage;
  import pipeline_types::*;

  localparam int DW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i = 1'b0;
  logic [DW-1:0]    fetch_valid_i = '0;
  logic [DW*32-1:0] fetch_inst_i = '0;
  logic [31:0]      fetch_pc_i = '0;
  logic             rename_ready_i = 1'b0;

  logic fetch_ready_o, nj_fetch_ready_o;
  logic [DW-1:0] dec_valid_o, nj_dec_valid_o;
  logic [DW*5-1:0] dec_rs1_o, dec_rs2_o, dec_rd_o;
  logic [DW*5-1:0] nj_rs1_o, nj_rs2_o, nj_rd_o;
  logic [DW-1:0] dec_rs1_valid_o, dec_rs2_valid_o, nj_rs1_valid_o, nj_rs2_valid_o;
  ctrl_payload_t [DW-1:0] dec_payload_o, nj_payload_o;

  decode_stage #(.DECODE_WIDTH(DW), .SKID_DEPTH(2), .ENABLE_JAL_AUIPC(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_inst_i(fetch_inst_i), .fetch_pc_i(fetch_pc_i),
    .fetch_ready_o(fetch_ready_o), .dec_valid_o(dec_valid_o),
    .dec_rs1_o(dec_rs1_o), .dec_rs2_o(dec_rs2_o), .dec_rd_o(dec_rd_o),
    .dec_rs1_valid_o(dec_rs1_valid_o), .dec_rs2_valid_o(dec_rs2_valid_o),
    .dec_payload_o(dec_payload_o), .rename_ready_i(rename_ready_i)
  );

  decode_stage #(.DECODE_WIDTH(DW), .SKID_DEPTH(2), .ENABLE_JAL_AUIPC(1'b0)) u_nj (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_inst_i(fetch_inst_i), .fetch_pc_i(fetch_pc_i),
    .fetch_ready_o(nj_fetch_ready_o), .dec_valid_o(nj_dec_valid_o),
    .dec_rs1_o(nj_rs1_o), .dec_rs2_o(nj_rs2_o), .dec_rd_o(nj_rd_o),
    .dec_rs1_valid_o(nj_rs1_valid_o), .dec_rs2_valid_o(nj_rs2_valid_o),
    .dec_payload_o(nj_payload_o), .rename_ready_i(rename_ready_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] flags(input ctrl_payload_t p);
    return {p.alu_src, p.reg_write, p.mem_read, p.mem_write,
            p.mem_to_reg, p.is_branch, p.is_jump, p.illegal};
  endfunction

  function automatic logic [16:0] regs(input int k);
    return {dec_rs1_o[5*k +: 5], dec_rs2_o[5*k +: 5], dec_rd_o[5*k +: 5],
            dec_rs1_valid_o[k], dec_rs2_valid_o[k]};
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [16:0] regs;
    logic [31:0] imm;
    logic [4:0]  alu_fu;
    logic [7:0]  fl;
    logic        nj_ill;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] inst, input logic [4:0] rs1, rs2, rd,
                              input logic rs1v, rs2v, input logic [31:0] imm,
                              input logic [2:0] alu, input logic [1:0] fu,
                              input logic [7:0] fl, input logic nj_ill);
    vec_t v;
    v.inst = inst; v.regs = {rs1, rs2, rd, rs1v, rs2v}; v.imm = imm;
    v.alu_fu = {alu, fu}; v.fl = fl; v.nj_ill = nj_ill;
    return v;
  endfunction

  vec_t vt [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // inst, rs1, rs2, rd, rs1v, rs2v, imm, alu, fu, flags{src,rw,mr,mw,m2r,br,j,ill}, nj_ill
    vt[0]  = mk(32'hFFF10093, 5'd2,  5'd0,  5'd1, 1, 0, 32'hFFFFFFFF, 3'b010, 2'd0, 8'hC0, 0); // addi x1,x2,-1
    vt[1]  = mk(32'h80006193, 5'd0,  5'd0,  5'd3, 1, 0, 32'h00000800, 3'b010, 2'd0, 8'hC0, 0); // ori x3,x0,0x800
    vt[2]  = mk(32'h123452B7, 5'd0,  5'd0,  5'd5, 0, 0, 32'h12345000, 3'b100, 2'd0, 8'h40, 0); // lui x5
    vt[3]  = mk(32'h00838333, 5'd7,  5'd8,  5'd6, 1, 1, 32'h00000000, 3'b001, 2'd0, 8'h40, 0); // add x6,x7,x8
    vt[4]  = mk(32'hFFC52483, 5'd10, 5'd0,  5'd9, 1, 0, 32'hFFFFFFFC, 3'b000, 2'd1, 8'hE8, 0); // lw x9,-4(x10)
    vt[5]  = mk(32'h00B62423, 5'd12, 5'd11, 5'd0, 1, 1, 32'h00000008, 3'b000, 2'd1, 8'h90, 0); // sw x11,8(x12)
    vt[6]  = mk(32'hFE208CE3, 5'd1,  5'd2,  5'd0, 1, 1, 32'hFFFFFFF8, 3'b011, 2'd2, 8'h04, 0); // beq x1,x2,-8
    vt[7]  = mk(32'hFE20ACE3, 5'd0,  5'd0,  5'd0, 0, 0, 32'h00000000, 3'b111, 2'd0, 8'h01, 1); // branch f3=010
    vt[8]  = mk(32'h000280E7, 5'd5,  5'd0,  5'd1, 1, 0, 32'h00000000, 3'b101, 2'd2, 8'hC2, 0); // jalr x1,0(x5)
    vt[9]  = mk(32'h008000EF, 5'd0,  5'd0,  5'd1, 0, 0, 32'h00000008, 3'b101, 2'd2, 8'hC2, 1); // jal x1,+8
    vt[10] = mk(32'h00001217, 5'd0,  5'd0,  5'd4, 0, 0, 32'h00001000, 3'b110, 2'd0, 8'hC0, 1); // auipc x4,1
    vt[11] = mk(32'h00000000, 5'd0,  5'd0,  5'd0, 0, 0, 32'h00000000, 3'b111, 2'd0, 8'h01, 1); // all-zero
    vt[12] = mk(32'h00000013, 5'd0,  5'd0,  5'd0, 1, 0, 32'h00000000, 3'b010, 2'd0, 8'h80, 0); // addi x0,x0,0

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_dec_valid", 64'(dec_valid_o), 64'd0);
    chk("reset_fetch_ready", 64'(fetch_ready_o), 64'd1);
    chk("reset_payload_zero", 64'(dec_payload_o == '0), 64'd1);
    chk("reset_regs_zero", 64'({dec_rs1_o, dec_rs2_o, dec_rd_o}), 64'd0);

    rename_ready_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      fetch_valid_i = 2'b01;
      fetch_inst_i  = {32'h0, vt[i].inst};
      fetch_pc_i    = 32'h2000 + 32'(16 * i);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(dec_valid_o), 64'd1);
      chk($sformatf("vec%0d_regs", i), 64'(regs(0)), 64'(vt[i].regs));
      chk($sformatf("vec%0d_imm", i), 64'(dec_payload_o[0].imm), 64'(vt[i].imm));
      chk($sformatf("vec%0d_alu_fu", i),
          64'({dec_payload_o[0].alu_op, dec_payload_o[0].fu_type}), 64'(vt[i].alu_fu));
      chk($sformatf("vec%0d_flags", i), 64'(flags(dec_payload_o[0])), 64'(vt[i].fl));
      chk($sformatf("vec%0d_pc_inst", i),
          {dec_payload_o[0].pc, dec_payload_o[0].inst}, {32'h2000 + 32'(16 * i), vt[i].inst});
      chk($sformatf("vec%0d_nojal_illegal", i), 64'(nj_payload_o[0].illegal), 64'(vt[i].nj_ill));
      fetch_valid_i = 2'b00;
      step();
    end
    chk("table_drained", 64'(dec_valid_o), 64'd0);

    // Two-lane group: addi + ori at PC 0x1000.
    fetch_valid_i = 2'b11;
    fetch_inst_i  = {32'h80006193, 32'hFFF10093};
    fetch_pc_i    = 32'h1000;
    step();
    chk("pair_valid", 64'(dec_valid_o), 64'd3);
    chk("pair_l0_rs1_rd", 64'({dec_rs1_o[4:0], dec_rd_o[4:0]}), 64'({5'd2, 5'd1}));
    chk("pair_l0_imm_alu", {dec_payload_o[0].imm, 29'd0, dec_payload_o[0].alu_op},
        {32'hFFFFFFFF, 29'd0, 3'b010});
    chk("pair_l1_imm", 64'(dec_payload_o[1].imm), 64'h800);
    chk("pair_l1_pc", 64'(dec_payload_o[1].pc), 64'h1004);
    chk("pair_l1_rd", 64'(dec_rd_o[9:5]), 64'd3);
    fetch_pc_i = 32'hFFFFFFFC;
    step();
    chk("pc_wrap_l0", 64'(dec_payload_o[0].pc), 64'hFFFFFFFC);
    chk("pc_wrap_l1", 64'(dec_payload_o[1].pc), 64'h0);
    fetch_valid_i = 2'b00;
    step();

    // Non-contiguous valid: lane 1 alone is never presented.
    fetch_valid_i = 2'b10;
    step();
    chk("mask_hole_cycle1", 64'(dec_valid_o), 64'd0);
    fetch_valid_i = 2'b00;
    step();
    chk("mask_hole_cycle2", 64'(dec_valid_o), 64'd0);

    // Back-pressure: three groups with rename stalled.
    rename_ready_i = 1'b0;
    fetch_valid_i  = 2'b11;
    fetch_inst_i   = {32'h00000013, 32'h00000013};
    fetch_pc_i = 32'h3000; step();
    chk("bp_ready_after_g1", 64'(fetch_ready_o), 64'd1);
    fetch_pc_i = 32'h3010; step();
    chk("bp_ready_after_g2", 64'(fetch_ready_o), 64'd0);
    fetch_pc_i = 32'h3020; step();
    chk("bp_g3_held_ready", 64'(fetch_ready_o), 64'd0);
    chk("bp_head_g1", 64'(dec_payload_o[0].pc), 64'h3000);
    rename_ready_i = 1'b1;
    step();
    chk("bp_head_g2", 64'(dec_payload_o[0].pc), 64'h3010);
    step();
    chk("bp_head_g3", 64'(dec_payload_o[0].pc), 64'h3020);
    chk("bp_g3_valid", 64'(dec_valid_o), 64'd3);
    fetch_valid_i = 2'b00;
    step();
    chk("bp_drained", 64'(dec_valid_o), 64'd0);

    // JAL + all-zero pair, both configurations.
    fetch_valid_i = 2'b11;
    fetch_inst_i  = {32'h00000000, 32'h008000EF};
    fetch_pc_i    = 32'h4000;
    step();
    chk("jal_l0_jump_imm_rw",
        {dec_payload_o[0].imm, 30'd0, dec_payload_o[0].is_jump, dec_payload_o[0].reg_write},
        {32'h8, 30'd0, 1'b1, 1'b1});
    chk("jal_l1_illegal_alu",
        64'({dec_payload_o[1].illegal, dec_payload_o[1].alu_op}), 64'({1'b1, 3'b111}));
    chk("jal_l1_still_valid", 64'(dec_valid_o), 64'd3);
    chk("nojal_l0_illegal",
        64'({nj_payload_o[0].illegal, nj_payload_o[0].alu_op, nj_payload_o[0].reg_write}),
        64'({1'b1, 3'b111, 1'b0}));
    fetch_valid_i = 2'b00;
    step();

    // Flush while full, with a group offered.
    rename_ready_i = 1'b0;
    fetch_valid_i  = 2'b11;
    fetch_pc_i = 32'h5000; step();
    fetch_pc_i = 32'h5010; step();
    chk("flush_full_ready", 64'(fetch_ready_o), 64'd0);
    flush_i = 1'b1;
    fetch_pc_i = 32'h5020;
    step();
    chk("flush_full_valid", 64'(dec_valid_o), 64'd0);
    chk("flush_full_ready_after", 64'(fetch_ready_o), 64'd1);
    flush_i = 1'b0; fetch_valid_i = 2'b00; rename_ready_i = 1'b1;
    step(); step();
    chk("flush_full_nothing_after", 64'(dec_valid_o), 64'd0);

    // Flush while the handshake fires: the accepted group is dropped.
    rename_ready_i = 1'b0;
    fetch_valid_i  = 2'b01;
    fetch_pc_i = 32'h6000; step();
    flush_i = 1'b1;
    fetch_pc_i = 32'h6010;
    step();
    chk("flush_hs_valid", 64'(dec_valid_o), 64'd0);
    flush_i = 1'b0; fetch_valid_i = 2'b00; rename_ready_i = 1'b1;
    step();
    chk("flush_hs_dropped", 64'(dec_valid_o), 64'd0);

    // Asynchronous reset between edges with data buffered.
    rename_ready_i = 1'b0;
    fetch_valid_i  = 2'b01;
    fetch_pc_i = 32'h7000; step();
    fetch_valid_i = 2'b00;
    chk("async_pre_valid", 64'(dec_valid_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(dec_valid_o), 64'd0);
    chk("async_rst_payload", 64'(dec_payload_o == '0), 64'd1);
    #1 rst = 1'b0;
    rename_ready_i = 1'b1;
    fetch_valid_i  = 2'b01;
    fetch_inst_i   = {32'h0, 32'h00000013};
    fetch_pc_i     = 32'h8000;
    step();
    chk("post_rst_x0_valid", 64'(dec_valid_o), 64'd1);
    chk("post_rst_x0_regwrite", 64'({dec_payload_o[0].reg_write, dec_rd_o[4:0]}), 64'd0);
    fetch_valid_i = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
